// File: rtl/idu_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, format classes
// and the decoded-entry record stored in the output and skid registers.
package idu_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SYS,
        FMT_NONE
    } fmt_e;

    // imm is kept at 32 bits; the stage sign-extends it to XLEN on the way out.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        csr_hit;
        logic        illegal;
    } decoded_t;

endpackage

// File: rtl/idu_decode.sv
// Purely combinational RV32/RV64 decoder: instruction word to decoded record
// plus the CSR table index.
module idu_decode
    import idu_pkg::*;
#(
    parameter int                    XLEN      = 32,
    parameter int                    NUM_CSR   = 4,
    parameter logic [NUM_CSR*12-1:0] CSR_ADDRS = {12'h305, 12'h342, 12'h300, 12'h341},
    parameter int                    CSR_IDX_W = 2
) (
    input  logic [31:0]          instr,
    output decoded_t             dec,
    output logic [CSR_IDX_W-1:0] csr_idx
);

    fmt_e                 fmt;
    logic                 is_fence;
    logic                 csr_match;
    logic [CSR_IDX_W-1:0] csr_first;

    always_comb begin
        fmt      = FMT_NONE;
        is_fence = 1'b0;
        unique case (instr[6:0])
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: fmt = FMT_I;
            OPC_MISC_MEM: begin
                fmt      = FMT_I;
                is_fence = 1'b1;
            end
            OPC_OP:               fmt = FMT_R;
            OPC_STORE:            fmt = FMT_S;
            OPC_BRANCH:           fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
            OPC_JAL:              fmt = FMT_J;
            OPC_SYSTEM:           fmt = FMT_SYS;
            OPC_OP_IMM32:         fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            OPC_OP32:             fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
            default:              fmt = FMT_NONE;
        endcase
    end

    // Walk downwards so the lowest matching table entry wins.
    always_comb begin
        csr_match = 1'b0;
        csr_first = '0;
        for (int i = NUM_CSR - 1; i >= 0; i--) begin
            if (instr[31:20] == CSR_ADDRS[12*i +: 12]) begin
                csr_match = 1'b1;
                csr_first = CSR_IDX_W'(i);
            end
        end
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = instr[6:0];
        dec.illegal = (fmt == FMT_NONE) || (instr[1:0] != 2'b11);
        csr_idx     = '0;
        if (!dec.illegal) begin
            csr_idx = csr_first;
            if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B, FMT_SYS}) begin
                dec.funct3 = instr[14:12];
                dec.rs1    = instr[19:15];
            end
            if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J, FMT_SYS}) begin
                dec.rd = instr[11:7];
            end
            if (fmt inside {FMT_R, FMT_S, FMT_B}) begin
                dec.rs2 = instr[24:20];
            end
            if (instr[6:0] inside {OPC_OP, OPC_OP32, OPC_OP_IMM, OPC_OP_IMM32}) begin
                dec.funct7 = instr[31:25];
            end
            dec.csr_hit = (fmt == FMT_SYS) && csr_match;
            unique case (fmt)
                FMT_I:   dec.imm = is_fence ? 32'd0 : {{20{instr[31]}}, instr[31:20]};
                FMT_S:   dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                FMT_B:   dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                FMT_U:   dec.imm = {instr[31:12], 12'b0};
                FMT_J:   dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                default: dec.imm = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage with a 2-entry skid buffer; in_ready depends only on
// the state register so upstream never sees a combinational path from out_ready.
module idu_stage
    import idu_pkg::*;
#(
    parameter int                    XLEN      = 32,
    parameter int                    NUM_CSR   = 4,
    parameter logic [NUM_CSR*12-1:0] CSR_ADDRS = {12'h305, 12'h342, 12'h300, 12'h341},
    parameter int                    CSR_IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [6:0]           out_opcode,
    output logic [2:0]           out_funct3,
    output logic [6:0]           out_funct7,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [XLEN-1:0]      out_imm,
    output logic [CSR_IDX_W-1:0] out_csr_idx,
    output logic                 out_csr_hit,
    output logic                 out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_e;

    state_e               state_q, state_d;
    decoded_t             in_dec, out_q, skid_q;
    logic [CSR_IDX_W-1:0] in_csr_idx, out_csr_idx_q, skid_csr_idx_q;
    logic [XLEN-1:0]      out_pc_q, skid_pc_q;
    logic                 accept, pop;
    logic                 load_out_in, load_out_skid, load_skid;

    idu_decode #(
        .XLEN      (XLEN),
        .NUM_CSR   (NUM_CSR),
        .CSR_ADDRS (CSR_ADDRS),
        .CSR_IDX_W (CSR_IDX_W)
    ) u_decode (
        .instr   (in_instr),
        .dec     (in_dec),
        .csr_idx (in_csr_idx)
    );

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flush wins over everything: no register loads and the FSM returns to EMPTY.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        load_out_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d       = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            out_q          <= '0;
            out_pc_q       <= '0;
            out_csr_idx_q  <= '0;
            skid_q         <= '0;
            skid_pc_q      <= '0;
            skid_csr_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_out_in) begin
                out_q         <= in_dec;
                out_pc_q      <= in_pc;
                out_csr_idx_q <= in_csr_idx;
            end else if (load_out_skid) begin
                out_q         <= skid_q;
                out_pc_q      <= skid_pc_q;
                out_csr_idx_q <= skid_csr_idx_q;
            end
            if (load_skid) begin
                skid_q         <= in_dec;
                skid_pc_q      <= in_pc;
                skid_csr_idx_q <= in_csr_idx;
            end
        end
    end

    assign out_pc      = out_pc_q;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_csr_idx = out_csr_idx_q;
    assign out_csr_hit = out_q.csr_hit;
    assign out_illegal = out_q.illegal;

    if (XLEN == 64) begin : g_imm_ext
        assign out_imm = {{(XLEN-32){out_q.imm[31]}}, out_q.imm};
    end else begin : g_imm_native
        assign out_imm = out_q.imm;
    end

endmodule

// File: tb/tb_idu_stage.sv
// Randomised bench for idu_stage: an RV32 and an RV64 instance share one input
// stream and are compared against a FIFO-of-instructions reference model.
module tb_idu_stage;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [1:0]  cidx;
        logic        hit;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        rdy32, vld32, hit32, ill32;
    logic [31:0] pc32, imm32;
    logic [6:0]  opc32, f7_32;
    logic [2:0]  f3_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [1:0]  cidx32;

    logic        rdy64, vld64, hit64, ill64;
    logic [63:0] pc64, imm64;
    logic [6:0]  opc64, f7_64;
    logic [2:0]  f3_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [1:0]  cidx64;

    int     checkCount = 0;
    int     passCount  = 0;
    item_t  q[$];
    bit     lastAccepted;
    logic [11:0] csrTab [4] = '{12'h341, 12'h300, 12'h342, 12'h305};
    logic [6:0]  opcTab [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                 7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B};

    always #5 clk = ~clk;

    idu_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(vld32), .out_ready(out_ready), .out_pc(pc32), .out_opcode(opc32),
        .out_funct3(f3_32), .out_funct7(f7_32), .out_rd(rd32), .out_rs1(rs1_32),
        .out_rs2(rs2_32), .out_imm(imm32), .out_csr_idx(cidx32), .out_csr_hit(hit32),
        .out_illegal(ill32)
    );

    idu_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(vld64), .out_ready(out_ready), .out_pc(pc64), .out_opcode(opc64),
        .out_funct3(f3_64), .out_funct7(f7_64), .out_rd(rd64), .out_rs1(rs1_64),
        .out_rs2(rs2_64), .out_imm(imm64), .out_csr_idx(cidx64), .out_csr_hit(hit64),
        .out_illegal(ill64)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference decode written from the instruction-set rules, not the RTL structure.
    function automatic exp_t refDecode(input logic [31:0] w, input bit rv64);
        exp_t   e;
        logic [6:0] op;
        bit     isI, isFence, isR, isS, isB, isU, isJ, isSys, isArith;
        longint v;
        e  = '0;
        op = w[6:0];
        e.opc   = op;
        isI     = (op == 7'h13) || (op == 7'h67) || (op == 7'h03) || (rv64 && op == 7'h1B);
        isFence = (op == 7'h0F);
        isR     = (op == 7'h33) || (rv64 && op == 7'h3B);
        isS     = (op == 7'h23);
        isB     = (op == 7'h63);
        isU     = (op == 7'h37) || (op == 7'h17);
        isJ     = (op == 7'h6F);
        isSys   = (op == 7'h73);
        isArith = (op == 7'h33) || (op == 7'h13) || (rv64 && (op == 7'h3B || op == 7'h1B));
        e.ill   = !(isI || isFence || isR || isS || isB || isU || isJ || isSys);
        if (e.ill) return e;
        if (isR || isI || isFence || isS || isB || isSys) begin
            e.f3  = w[14:12];
            e.rs1 = w[19:15];
        end
        if (isR || isI || isFence || isU || isJ || isSys) e.rd = w[11:7];
        if (isR || isS || isB) e.rs2 = w[24:20];
        if (isArith) e.f7 = w[31:25];
        v = 0;
        if (isI)      v = $signed(w[31:20]);
        else if (isS) v = $signed({w[31:25], w[11:7]});
        else if (isB) v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        else if (isU) v = $signed({w[31:12], 12'b0});
        else if (isJ) v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        e.imm = v;
        for (int i = 0; i < 4; i++) begin
            if (w[31:20] == csrTab[i]) begin
                e.cidx = 2'(i);
                e.hit  = isSys;
                break;
            end
        end
        return e;
    endfunction

    task automatic compareDut();
        exp_t e32, e64;
        checkOutput("valid32", vld32, q.size() > 0);
        checkOutput("ready32", rdy32, q.size() < 2);
        checkOutput("valid64", vld64, q.size() > 0);
        checkOutput("ready64", rdy64, q.size() < 2);
        if (q.size() > 0) begin
            e32 = refDecode(q[0].instr, 1'b0);
            e64 = refDecode(q[0].instr, 1'b1);
            checkOutput("pc32", pc32, q[0].pc[31:0]);
            checkOutput("opc32", opc32, e32.opc);
            checkOutput("f3_32", f3_32, e32.f3);
            checkOutput("f7_32", f7_32, e32.f7);
            checkOutput("regs32", {rd32, rs1_32, rs2_32}, {e32.rd, e32.rs1, e32.rs2});
            checkOutput("imm32", imm32, e32.imm[31:0]);
            checkOutput("csr32", {hit32, cidx32}, {e32.hit, e32.cidx});
            checkOutput("ill32", ill32, e32.ill);
            checkOutput("pc64", pc64, q[0].pc);
            checkOutput("opc64", opc64, e64.opc);
            checkOutput("f3_64", f3_64, e64.f3);
            checkOutput("f7_64", f7_64, e64.f7);
            checkOutput("regs64", {rd64, rs1_64, rs2_64}, {e64.rd, e64.rs1, e64.rs2});
            checkOutput("imm64", imm64, e64.imm);
            checkOutput("csr64", {hit64, cidx64}, {e64.hit, e64.cidx});
            checkOutput("ill64", ill64, e64.ill);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                                 input logic ordy, input logic fl);
        bit popNow, accNow;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        lastAccepted = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            popNow = (q.size() > 0) && ordy;
            accNow = v && (q.size() < 2);
            if (popNow) void'(q.pop_front());
            if (accNow) q.push_back('{instr: instr, pc: pc});
            lastAccepted = accNow;
        end
        #1 compareDut();
        @(negedge clk);
    endtask

    function automatic logic [31:0] genInstr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 15);
        if (r < 13) w[6:0] = opcTab[r];
        else if (r == 13) w[6:0] = 7'h73;
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w[31:20] = csrTab[$urandom_range(0, 3)];
        return w;
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", {vld32, vld64}, 2'b00);
        checkOutput("rst_ready", {rdy32, rdy64}, 2'b11);
        checkOutput("rst_fields32", {pc32, imm32, opc32, rd32, ill32}, '0);
        checkOutput("rst_fields64", imm64 | pc64 | 64'(opc64) | 64'(ill64), '0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1, 32'hFFF10093, 64'h100, 1, 0);
        checkOutput("addi_regs", {rd32, rs1_32, rs2_32}, {5'd1, 5'd2, 5'd0});
        checkOutput("addi_f7f3", {f7_32, f3_32}, {7'h7F, 3'd0});
        checkOutput("addi_imm", imm32, 32'hFFFFFFFF);
        applyStimulus(1, 32'h341312F3, 64'h104, 1, 0);
        checkOutput("csrrw_regs", {rd32, rs1_32, f3_32}, {5'd5, 5'd6, 3'd1});
        checkOutput("csrrw_csr", {hit32, cidx32, imm32}, {1'b1, 2'd0, 32'd0});
        applyStimulus(1, 32'hFFDFF0EF, 64'h108, 1, 0);
        checkOutput("jal_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        checkOutput("jal_regs64", {rd64, rs1_64}, {5'd1, 5'd0});
        applyStimulus(1, 32'h00000000, 64'h10C, 1, 0);
        checkOutput("zero_ill", {ill32, ill64, rd32, rs1_32, rs2_32}, {2'b11, 15'd0});
        applyStimulus(1, 32'h0000003B, 64'h110, 1, 0);
        checkOutput("op32_ill", {ill32, ill64}, 2'b10);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        // Back-pressure: three offers while stalled, then drain in order.
        applyStimulus(1, 32'h00A00513, 64'h200, 0, 0);
        applyStimulus(1, 32'h00B00593, 64'h204, 0, 0);
        checkOutput("bp_ready_low", rdy32, 1'b0);
        applyStimulus(1, 32'h00C00613, 64'h208, 0, 0);
        for (int i = 0; i < 8 && !lastAccepted; i++) applyStimulus(1, 32'h00C00613, 64'h208, 1, 0);
        checkOutput("bp_third_accepted", lastAccepted, 1'b1);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        // Flush from the full state with a new instruction offered.
        applyStimulus(1, 32'h00100093, 64'h300, 0, 0);
        applyStimulus(1, 32'h00200113, 64'h304, 0, 0);
        applyStimulus(1, 32'h00300193, 64'h308, 0, 1);
        checkOutput("flush_state", {vld32, rdy32, vld64, rdy64}, 4'b0101);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(logic'($urandom_range(0, 3) != 0), genInstr(), {$urandom, $urandom},
                          logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 24) == 0));
            if (n == 200) begin
                #2 rst_n = 1'b0;
                #1 q.delete();
                checkOutput("async_rst", {vld32, rdy32, vld64, rdy64, ill32, opc64}, {4'b0101, 8'd0});
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
